vip_gray_binarize: RTL

//  Stage downstream of the RGB565 grayscale converter. Input is grey pixels replicated into R/G/B.

---
 rtl/vip_gray_binarize.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vip_gray_binarize.sv
// Grey-to-binary pixel stage: 2-cycle compare pipeline plus per-frame mean-luma
// threshold computed by a serial restoring divider during vertical blanking.
module vip_gray_binarize #(
    parameter int         CNT_W       = 22,
    parameter int         SUM_W       = 30,
    parameter logic [7:0] INIT_THRESH = 8'd128,
    parameter logic       VS_POL      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        thresh_mode,
    input  logic [7:0]  manual_thresh,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_hsync,
    input  logic        pre_frame_de,
    input  logic [15:0] pre_rgb,
    output logic        post_frame_vsync,
    output logic        post_frame_hsync,
    output logic        post_frame_de,
    output logic [15:0] post_rgb,
    output logic [7:0]  thresh_o,
    output logic        mean_valid
);

    localparam int BC_W = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_y_s1;
    logic [7:0]       r_thr_s1;
    logic             r_vs_s1;
    logic             r_hs_s1;
    logic             r_de_s1;
    logic             r_post_vs;
    logic             r_post_hs;
    logic             r_post_de;
    logic [15:0]      r_post_rgb;
    logic             r_vs_prev;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] r_quo;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_divisor;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [7:0]       r_thresh;
    logic             r_mean_valid;

    logic [7:0]       w_y;
    logic             w_frame_end;
    logic             w_start;
    logic [SUM_W:0]   w_sum_ext;
    logic [SUM_W-1:0] w_sum_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W:0]   w_rem_sh;
    logic [CNT_W:0]   w_diff;
    logic             w_ge;
    logic [7:0]       w_q_sat;

    assign w_y         = {pre_rgb[10:5], pre_rgb[10:9]};
    assign w_frame_end = (pre_frame_vsync == VS_POL) && (r_vs_prev != VS_POL);
    assign w_start     = w_frame_end && (r_cnt != {CNT_W{1'b0}});

    // Saturating accumulators: stick at all-ones rather than wrapping on huge frames
    assign w_sum_ext  = {1'b0, r_sum} + {{(SUM_W - 7){1'b0}}, w_y};
    assign w_sum_next = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
    assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W - 1){1'b0}}, 1'b1};

    // One restoring-division step: shift in next dividend bit, subtract if it fits
    assign w_rem_sh = {r_rem, r_quo[SUM_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_divisor};
    assign w_ge     = (w_rem_sh >= {1'b0, r_divisor});
    assign w_q_sat  = (|r_quo[SUM_W-1:8]) ? 8'hFF : r_quo[7:0];

    // Stage 1 / stage 2 pixel pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_s1     <= 8'd0;
            r_thr_s1   <= 8'd0;
            r_vs_s1    <= 1'b0;
            r_hs_s1    <= 1'b0;
            r_de_s1    <= 1'b0;
            r_post_vs  <= 1'b0;
            r_post_hs  <= 1'b0;
            r_post_de  <= 1'b0;
            r_post_rgb <= 16'h0000;
        end else begin
            r_y_s1     <= w_y;
            r_thr_s1   <= thresh_mode ? manual_thresh : r_thresh;
            r_vs_s1    <= pre_frame_vsync;
            r_hs_s1    <= pre_frame_hsync;
            r_de_s1    <= pre_frame_de;
            r_post_vs  <= r_vs_s1;
            r_post_hs  <= r_hs_s1;
            r_post_de  <= r_de_s1;
            r_post_rgb <= (r_de_s1 && (r_y_s1 > r_thr_s1)) ? 16'hFFFF : 16'h0000;
        end
    end

    // Frame statistics; a pixel on the frame-end cycle already belongs to the new frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev <= ~VS_POL;
            r_sum     <= {SUM_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
        end else begin
            r_vs_prev <= pre_frame_vsync;
            if (w_frame_end) begin
                r_sum <= pre_frame_de ? {{(SUM_W - 8){1'b0}}, w_y} : {SUM_W{1'b0}};
                r_cnt <= pre_frame_de ? {{(CNT_W - 1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
            end else if (pre_frame_de) begin
                r_sum <= w_sum_next;
                r_cnt <= w_cnt_next;
            end
        end
    end

    // Mean FSM: any non-empty frame end (re)starts the divide, an empty one abandons it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_quo        <= {SUM_W{1'b0}};
            r_rem        <= {CNT_W{1'b0}};
            r_divisor    <= {CNT_W{1'b0}};
            r_bit_cnt    <= {BC_W{1'b0}};
            r_thresh     <= INIT_THRESH;
            r_mean_valid <= 1'b0;
        end else begin
            r_mean_valid <= 1'b0;
            if (r_state == S_DONE) begin
                r_thresh     <= w_q_sat;
                r_mean_valid <= 1'b1;
            end
            if (w_start) begin
                r_quo     <= r_sum;
                r_divisor <= r_cnt;
                r_rem     <= {CNT_W{1'b0}};
                r_bit_cnt <= BC_W'(SUM_W - 1);
                r_state   <= S_DIV;
            end else if (w_frame_end) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_IDLE;
                    S_DIV: begin
                        r_quo <= {r_quo[SUM_W-2:0], w_ge};
                        r_rem <= w_ge ? w_diff[CNT_W-1:0] : w_rem_sh[CNT_W-1:0];
                        if (r_bit_cnt == {BC_W{1'b0}}) begin
                            r_state <= S_DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - {{(BC_W - 1){1'b0}}, 1'b1};
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign post_frame_vsync = r_post_vs;
    assign post_frame_hsync = r_post_hs;
    assign post_frame_de    = r_post_de;
    assign post_rgb         = r_post_rgb;
    assign thresh_o         = r_thresh;
    assign mean_valid       = r_mean_valid;

endmodule
